// File: rtl/hamming_pkg.sv
// Shared types and constants for the 16-bit SEC-DED scrub monitor.
// Codeword positions run 1..21; check bits sit at the power-of-two positions.
package hamming_pkg;
  localparam int DATA_W = 16;
  localparam int CHK_W  = 6;
  localparam int SYN_W  = 5;
  localparam int NPOS   = 21;

  typedef enum logic [1:0] {
    ERR_CLEAN = 2'b00,
    ERR_SEC   = 2'b01,
    ERR_DED   = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    HEALTH_NORMAL   = 2'b00,
    HEALTH_DEGRADED = 2'b01,
    HEALTH_FAILED   = 2'b10
  } health_e;

  typedef logic [SYN_W-1:0] pos_map_t [DATA_W];

  // Codeword position of each data bit, data bit 0 first.
  localparam pos_map_t DATA_POS = '{
    5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12,
    5'd13, 5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21
  };
endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity evaluation of one 22-bit codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [CHK_W-1:0]  check_i,
  output logic [SYN_W-1:0]  syndrome_o,
  output logic              overall_o
);
  logic [SYN_W-1:0] syn;

  always_comb begin
    syn = '0;
    for (int i = 0; i < SYN_W; i++) begin
      if (check_i[i]) syn = syn ^ SYN_W'(1 << i);
    end
    for (int i = 0; i < DATA_W; i++) begin
      if (data_i[i]) syn = syn ^ DATA_POS[i];
    end
  end

  assign syndrome_o = syn;
  assign overall_o  = ^{data_i, check_i};
endmodule

// File: rtl/hamming_scrub_monitor.sv
// Two-stage SEC-DED corrector with valid/ready handshake and optional error
// statistics, compiled in when HAMMING_MON_STATS_EN is defined.
module hamming_scrub_monitor
  import hamming_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int SEC_THRESH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_check,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err,
  input  logic              clear_counts,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic [SYN_W-1:0]  last_syndrome,
  output logic [1:0]        health
);
  logic [SYN_W-1:0]  syn_s1;
  logic              ovr_s1;
  logic              vld_p1_q, ovr_p1_q;
  logic [DATA_W-1:0] data_p1_q;
  logic [SYN_W-1:0]  syn_p1_q;
  logic              vld_p2_q;
  logic [DATA_W-1:0] data_p2_q, data_p2_d;
  err_e              err_p2_q, err_p2_d;
  logic [SYN_W-1:0]  syn_p2_q;
  logic              adv_p2, take_p1, xfer;

  assign adv_p2   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p2;
  assign take_p1  = in_valid && in_ready;
  assign xfer     = vld_p2_q && out_ready;

  hamming_syndrome u_syndrome (
    .data_i     (in_data),
    .check_i    (in_check),
    .syndrome_o (syn_s1),
    .overall_o  (ovr_s1)
  );

  // ---- stage 1: register syndrome, overall parity and raw data ----
  always_ff @(posedge clk) begin
    if (reset) vld_p1_q <= 1'b0;
    else if (in_ready) vld_p1_q <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (take_p1) begin
      data_p1_q <= in_data;
      syn_p1_q  <= syn_s1;
      ovr_p1_q  <= ovr_s1;
    end
  end

  // ---- stage 2: classify and correct ----
  always_comb begin
    err_p2_d  = ERR_CLEAN;
    data_p2_d = data_p1_q;
    if (syn_p1_q == '0) begin
      if (ovr_p1_q) err_p2_d = ERR_SEC;
    end else if (ovr_p1_q && (syn_p1_q <= SYN_W'(NPOS))) begin
      // A check-bit position matches no data bit, leaving the data untouched.
      err_p2_d = ERR_SEC;
      for (int i = 0; i < DATA_W; i++) begin
        if (DATA_POS[i] == syn_p1_q) data_p2_d[i] = ~data_p1_q[i];
      end
    end else begin
      err_p2_d = ERR_DED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      err_p2_q  <= ERR_CLEAN;
      syn_p2_q  <= '0;
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        data_p2_q <= data_p2_d;
        err_p2_q  <= err_p2_d;
        syn_p2_q  <= syn_p1_q;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_err   = err_p2_q;

`ifdef HAMMING_MON_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] sec_q, ded_q;
  logic [SYN_W-1:0] lsyn_q;
  health_e          health_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Statistics move only on output transfers; clear wins over a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (reset || clear_counts) begin
      sec_q    <= '0;
      ded_q    <= '0;
      lsyn_q   <= '0;
      health_q <= HEALTH_NORMAL;
    end else if (xfer && (err_p2_q != ERR_CLEAN)) begin
      lsyn_q <= syn_p2_q;
      if (err_p2_q == ERR_DED) begin
        ded_q    <= sat_inc(ded_q);
        health_q <= HEALTH_FAILED;
      end else begin
        sec_q <= sat_inc(sec_q);
        if ((health_q == HEALTH_NORMAL) && (sat_inc(sec_q) >= CNT_W'(SEC_THRESH)))
          health_q <= HEALTH_DEGRADED;
      end
    end
  end

  assign sec_count     = sec_q;
  assign ded_count     = ded_q;
  assign last_syndrome = lsyn_q;
  assign health        = health_q;
`else
  logic unused_stats;
  assign unused_stats  = ^{clear_counts, syn_p2_q, xfer, (SEC_THRESH != 0)};
  assign sec_count     = '0;
  assign ded_count     = '0;
  assign last_syndrome = '0;
  assign health        = HEALTH_NORMAL;
`endif
endmodule

// File: tb/tb_hamming_scrub_monitor.sv
// Scoreboard bench for hamming_scrub_monitor: directed codewords with hand-computed
// results; statistics expectations collapse to zero when the stats build is off.
`timescale 1ns/1ps
module tb_hamming_scrub_monitor;
  import hamming_pkg::*;

  localparam int CNT_W = 8;
`ifdef HAMMING_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_data = '0;
  logic [5:0]        in_check = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       out_data;
  logic [1:0]        out_err;
  logic              clear_counts = 1'b0;
  logic [CNT_W-1:0]  sec_count, ded_count;
  logic [4:0]        last_syndrome;
  logic [1:0]        health;

  always #5 clk = ~clk;

  hamming_scrub_monitor #(.CNT_W(CNT_W), .SEC_THRESH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_check      (in_check),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_err       (out_err),
    .clear_counts  (clear_counts),
    .sec_count     (sec_count),
    .ded_count     (ded_count),
    .last_syndrome (last_syndrome),
    .health        (health)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int st(input int v);
    return STATS ? v : 0;
  endfunction

  // Monitor: pops on every output transfer and checks hold-stability under stall.
  logic        hold_vld = 1'b0;
  logic [15:0] hold_data = '0;
  logic [1:0]  hold_err = '0;

  always @(negedge clk) begin
    if (reset) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && out_valid) begin
        check("stall_data_stable", out_data, hold_data);
        check("stall_err_stable", out_err, hold_err);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          exp_cur = exp_q.pop_front();
          check("out_data", out_data, exp_cur.data);
          check("out_err", out_err, exp_cur.err);
        end
        hold_vld = 1'b0;
      end else begin
        hold_vld  = out_valid;
        hold_data = out_data;
        hold_err  = out_err;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic [5:0] c,
                      input logic [15:0] ed, input logic [1:0] ee);
    int n = 0;
    in_data  = d;
    in_check = c;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_accept_timeout", in_ready, 1);
      @(posedge clk);
      #1;
    end else begin
      exp_q.push_back({ed, ee});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      tick(1);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    tick(1);
  endtask

  task automatic check_stats(input string tag, input int sec, input int ded,
                             input int lsyn, input int hl);
    check({"sec_count_", tag}, sec_count, st(sec));
    check({"ded_count_", tag}, ded_count, st(ded));
    check({"last_syndrome_", tag}, last_syndrome, st(lsyn));
    check({"health_", tag}, health, st(hl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check_stats("rst", 0, 0, 0, 0);

    // Clean zero codeword, two-cycle latency
    send(16'h0000, 6'h00, 16'h0000, ERR_CLEAN);
    check("lat_cycle1_out_valid", out_valid, 0);
    tick(1);
    check("lat_cycle2_out_valid", out_valid, 1);
    drain();

    // Single data-bit error at position 3
    send(16'h0001, 6'h00, 16'h0000, ERR_SEC);
    drain();
    check_stats("sec_pos3", 1, 0, 3, 0);

    // Clean non-trivial codewords; last_syndrome holds
    send(16'h0001, 6'h23, 16'h0001, ERR_CLEAN);
    send(16'hFFFF, 6'h1E, 16'hFFFF, ERR_CLEAN);
    drain();
    check_stats("after_clean", 1, 0, 3, 0);

    // Overall parity bit alone flipped
    send(16'h0000, 6'h20, 16'h0000, ERR_SEC);
    drain();
    check_stats("sec_parity", 2, 0, 0, 0);

    // Highest position (21) corrected
    send(16'h7FFF, 6'h1E, 16'hFFFF, ERR_SEC);
    drain();
    check_stats("sec_pos21", 3, 0, 21, 0);

    // Check-bit error at position 4: fourth SEC degrades health
    send(16'h0000, 6'h04, 16'h0000, ERR_SEC);
    drain();
    check_stats("sec_fourth", 4, 0, 4, 1);

    // Backpressure: two accepts fill the pipe, then in_ready drops
    out_ready = 1'b0;
    send(16'h0001, 6'h23, 16'h0001, ERR_CLEAN);
    send(16'hFFFF, 6'h1E, 16'hFFFF, ERR_CLEAN);
    in_data = 16'h0000; in_check = 6'h00; in_valid = 1'b1;
    check("bp_in_ready_0", in_ready, 0);
    tick(1);
    check("bp_in_ready_1", in_ready, 0);
    tick(1);
    check("bp_out_valid_held", out_valid, 1);
    out_ready = 1'b1;
    send(16'h0000, 6'h00, 16'h0000, ERR_CLEAN);
    drain();
    check_stats("after_bp", 4, 0, 4, 1);

    // Fifth SEC transferred in the same cycle as clear_counts
    out_ready = 1'b0;
    send(16'h0001, 6'h00, 16'h0000, ERR_SEC);
    tick(1);
    check("clr_out_valid", out_valid, 1);
    clear_counts = 1'b1;
    out_ready = 1'b1;
    tick(1);
    clear_counts = 1'b0;
    check_stats("clear_with_sec", 0, 0, 0, 0);
    drain();

    // Double error: FAILED and sticky across a clean codeword
    send(16'h0003, 6'h00, 16'h0003, ERR_DED);
    drain();
    check_stats("ded_pos35", 0, 1, 6, 2);
    send(16'h0000, 6'h00, 16'h0000, ERR_CLEAN);
    drain();
    check_stats("failed_sticky", 0, 1, 6, 2);

    // Syndrome beyond position 21 is uncorrectable
    send(16'h0000, 6'h1F, 16'h0000, ERR_DED);
    drain();
    check_stats("ded_syn31", 0, 2, 31, 2);

    clear_counts = 1'b1;
    tick(1);
    clear_counts = 1'b0;
    check_stats("clear_alone", 0, 0, 0, 0);

    // DED counter saturation
    for (int i = 0; i < 260; i++) send(16'h0003, 6'h00, 16'h0003, ERR_DED);
    drain();
    check_stats("ded_saturate", 0, 255, 6, 2);

    // Reset mid-operation discards in-flight codewords
    out_ready = 1'b0;
    send(16'h0001, 6'h23, 16'h0001, ERR_CLEAN);
    send(16'hFFFF, 6'h1E, 16'hFFFF, ERR_CLEAN);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_data", out_data, 0);
    check_stats("midrst", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_out_valid", out_valid, 0);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hamming_scrub_monitor.md
HAMMING_SCRUB_MONITOR -- requirements
Module: hamming_scrub_monitor

Interface
REQ-001 SHALL have parameters: CNT_W, 8, width of error counters; SEC_THRESH, 4, SEC count at which health goes DEGRADED.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  in  1  codeword present; in_ready  out  1  codeword accepted when both high.
REQ-005 SHALL have ports: in_data  in  16  protected counter value; in_check  in  6  check bits [4:0] Hamming, [5] overall parity.
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  16  corrected value; out_err  out  2  00 clean, 01 SEC, 10 DED.
REQ-007 SHALL have ports: clear_counts  in  1  clears counters and health; sec_count, ded_count  out  CNT_W; last_syndrome  out  5; health  out  2  00 NORMAL, 01 DEGRADED, 10 FAILED.

Function
REQ-008 SHALL use codeword positions 1..21: in_check[i] at position 2^i (i=0..4), in_data[0..15] at the remaining positions in ascending order.
REQ-009 SHALL define in_check[5] as the XOR of all 21 positions; an even-parity mismatch is signalled by overall = XOR(all 22 bits) = 1.
REQ-010 SHALL compute syndrome = XOR of the indices of all set positions; stage 1 registers syndrome, overall, and the data.
REQ-011 SHALL classify in stage 2: syn=0,ovr=0 clean; syn!=0,ovr=1,syn<=21 SEC, flip that position; syn=0,ovr=1 SEC, data unchanged; syn!=0,ovr=0 or syn>21 DED, data passed uncorrected.
REQ-012 SHALL have latency 2 cycles from in_valid&in_ready to out_valid with no stall.
REQ-013 SHALL advance each stage when its downstream slot is empty or draining; in_ready = !s1_valid || s1 advancing; no combinational path from in_valid to out_valid.
REQ-014 SHALL hold out_data/out_err stable while out_valid=1 and out_ready=0; no codeword lost or duplicated.
REQ-015 SHALL update counters, last_syndrome and health only when a codeword is transferred out (out_valid&out_ready).
REQ-016 SHALL saturate sec_count and ded_count at 2^CNT_W-1.
REQ-017 SHALL load last_syndrome on every non-clean transfer; it holds otherwise.
REQ-018 SHALL implement health FSM: NORMAL->DEGRADED when sec_count reaches SEC_THRESH; any state->FAILED on DED; FAILED is sticky.
REQ-019 SHALL, on clear_counts, zero the counters and last_syndrome and return health to NORMAL, taking priority over a same-cycle transfer's statistics; the data transfer itself still completes.

Reset
REQ-020 SHALL on reset clear both stage valids, so out_valid=0 and in_ready=1 on the following cycle, and set out_data=0, out_err=00, counters=0, last_syndrome=0, health=NORMAL.
REQ-021 SHALL discard in-flight codewords on reset mid-operation; no out_valid from pre-reset inputs.

Configuration
REQ-022 SHALL compile statistics in only when HAMMING_MON_STATS_EN is defined: with it, REQ-015..019 apply.
REQ-023 SHALL, when HAMMING_MON_STATS_EN is undefined, tie sec_count, ded_count, last_syndrome to 0 and health to NORMAL; correction and handshake are unchanged.

Structure
REQ-024 SHALL place the out_err and health enum typedefs, the data width 16, check width 6, and the position map constant in a shared package hamming_pkg.
REQ-025 SHALL implement syndrome/overall computation as sub-module hamming_syndrome (combinational) instantiated in stage 1.

Verification
REQ-026 SHALL verify: in_data=0x0000, in_check=0x00 -> out_data=0x0000, out_err=00, 2 cycles later.
REQ-027 SHALL verify: in_data=0x0001 (pos 3), in_check=0x00 -> out_data=0x0000, out_err=01, last_syndrome=3, sec_count=1.
REQ-028 SHALL verify: in_data=0x0003 (pos 3,5), in_check=0x00 -> out_err=10, out_data=0x0003, ded_count=1, health=FAILED until clear_counts.
REQ-029 SHALL verify: in_data=0x0000, in_check=0x20 -> out_err=01, out_data=0x0000, last_syndrome=0.
REQ-030 SHALL verify: 4 SEC codewords -> health=DEGRADED after the 4th transfer; clear_counts in the same cycle as a 5th SEC -> sec_count=0, health=NORMAL.
REQ-031 SHALL verify: out_ready=0 for 3 cycles with continuous in_valid -> in_ready=0 after 2 accepts, out_data stable, all codewords delivered in order after release.
